mem_scan_ctrl: RTL and testbench

Sequencer that drives the single-port-pair block RAM (`memory`, 1-cycle registered read, unconditional write every clock) for bitstream reinit experiments.
- FILL: writes a deterministic pattern over an address range.
- CHECK: reads the range back, compares each word against the same pattern, and reports the mismatch count and the first failing address.
- The RAM has no write enable, so whenever this block is not filling, it parks the write port on a reserved scratch address.
- Sits between the test top and `memory`; it owns the memory's raddr/waddr/din and consumes its dout.

---
 rtl/mem_scan_ctrl_if.sv | 13 +
 rtl/mem_scan_ctrl.sv | 160 ++++++++++++++++
 tb/tb_mem_scan_ctrl.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_scan_ctrl_if.sv
// Memory-side bus between the scan sequencer and the block RAM.
// The master drives both address ports and write data; the RAM returns registered read data.
interface mem_scan_ctrl_if #(
    parameter int WID_MEM = 8
) ();
    logic [31:0]        mem_raddr;
    logic [31:0]        mem_waddr;
    logic [WID_MEM-1:0] mem_din;
    logic [WID_MEM-1:0] mem_dout;

    modport master (output mem_raddr, mem_waddr, mem_din, input mem_dout);
    modport slave  (input mem_raddr, mem_waddr, mem_din, output mem_dout);
endinterface

// File: rtl/mem_scan_ctrl.sv
// Fill/check sequencer for a write-every-clock block RAM.
// It writes a pattern over a range, or reads the range back and counts mismatches.
module mem_scan_ctrl #(
    parameter int                 WID_MEM   = 8,
    parameter int                 DEPTH_MEM = 16384,
    parameter int                 PARK_ADDR = DEPTH_MEM - 1,
    parameter logic [WID_MEM-1:0] PARK_DATA = '0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               op,
    input  logic [1:0]         mode,
    input  logic [WID_MEM-1:0] seed,
    input  logic [31:0]        start_addr,
    input  logic [31:0]        end_addr,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic               cfg_err,
    output logic               aborted,
    output logic [31:0]        err_cnt,
    output logic               first_err_valid,
    output logic [31:0]        first_err_addr,
    mem_scan_ctrl_if.master    mem
);
    localparam logic [31:0] DEPTH_W = 32'(DEPTH_MEM);
    localparam logic [31:0] PARK_W  = 32'(PARK_ADDR);

    typedef enum logic [2:0] {IDLE, FILL, READ, DRAIN, DONE} state_t;

    state_t             state;
    logic [1:0]         mode_q;
    logic [WID_MEM-1:0] seed_q;
    logic [31:0]        end_q;
    logic               pipe_vld;
    logic [31:0]        pipe_addr;
    logic               reject;
    logic               miss;

    function automatic logic [WID_MEM-1:0] pattern(input logic [1:0] m,
                                                   input logic [WID_MEM-1:0] s,
                                                   input logic [31:0] a);
        case (m)
            2'd0:    return s;
            2'd1:    return a[WID_MEM-1:0] ^ s;
            default: return ~a[WID_MEM-1:0] ^ s;
        endcase
    endfunction

    // Ranges touching the park word are refused: a fill there would be clobbered every idle clock.
    assign reject = (start_addr > end_addr) || (end_addr >= DEPTH_W) ||
                    ((start_addr <= PARK_W) && (PARK_W <= end_addr)) || (mode == 2'd3);

    assign miss = pipe_vld && (mem.mem_dout != pattern(mode_q, seed_q, pipe_addr));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            busy            <= 1'b0;
            done            <= 1'b0;
            cfg_err         <= 1'b0;
            aborted         <= 1'b0;
            err_cnt         <= '0;
            first_err_valid <= 1'b0;
            first_err_addr  <= '0;
            mode_q          <= '0;
            seed_q          <= '0;
            end_q           <= '0;
            pipe_vld        <= 1'b0;
            pipe_addr       <= '0;
            mem.mem_raddr   <= '0;
            mem.mem_waddr   <= PARK_W;
            mem.mem_din     <= PARK_DATA;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    mem.mem_waddr <= PARK_W;
                    mem.mem_din   <= PARK_DATA;
                    if (start) begin
                        mode_q <= mode;
                        seed_q <= seed;
                        end_q  <= end_addr;
                        busy   <= 1'b1;
                        if (reject) begin
                            cfg_err <= 1'b1;
                            done    <= 1'b1;
                            state   <= DONE;
                        end else begin
                            cfg_err         <= 1'b0;
                            aborted         <= 1'b0;
                            err_cnt         <= '0;
                            first_err_valid <= 1'b0;
                            pipe_vld        <= 1'b0;
                            if (!op) begin
                                state         <= FILL;
                                mem.mem_waddr <= start_addr;
                                mem.mem_din   <= pattern(mode, seed, start_addr);
                            end else begin
                                state         <= READ;
                                mem.mem_raddr <= start_addr;
                            end
                        end
                    end
                end
                FILL, READ, DRAIN: begin
                    if (abort) begin
                        state         <= DONE;
                        done          <= 1'b1;
                        aborted       <= 1'b1;
                        pipe_vld      <= 1'b0;
                        mem.mem_waddr <= PARK_W;
                        mem.mem_din   <= PARK_DATA;
                    end else begin
                        if (miss) begin
                            if (err_cnt != '1)
                                err_cnt <= err_cnt + 32'd1;
                            if (!first_err_valid) begin
                                first_err_valid <= 1'b1;
                                first_err_addr  <= pipe_addr;
                            end
                        end
                        if (state == FILL) begin
                            if (mem.mem_waddr == end_q) begin
                                state         <= DONE;
                                done          <= 1'b1;
                                mem.mem_waddr <= PARK_W;
                                mem.mem_din   <= PARK_DATA;
                            end else begin
                                mem.mem_waddr <= mem.mem_waddr + 32'd1;
                                mem.mem_din   <= pattern(mode_q, seed_q, mem.mem_waddr + 32'd1);
                            end
                        end else if (state == READ) begin
                            // The address just presented is compared when its data returns next cycle.
                            pipe_vld  <= 1'b1;
                            pipe_addr <= mem.mem_raddr;
                            if (mem.mem_raddr == end_q)
                                state <= DRAIN;
                            else
                                mem.mem_raddr <= mem.mem_raddr + 32'd1;
                        end else begin
                            pipe_vld <= 1'b0;
                            state    <= DONE;
                            done     <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_scan_ctrl.sv
// Scoreboard bench: a shadow RAM and result model predict each completion; a monitor checks done pulses.
module tb_mem_scan_ctrl;
    localparam int D    = 16384;
    localparam int PARK = D - 1;

    logic        clk = 1'b0, reset_n = 1'b1;
    logic        start = 1'b0, op = 1'b0, abort = 1'b0;
    logic [1:0]  mode = '0;
    logic [7:0]  seed = '0;
    logic [31:0] sa = '0, ea = '0;
    logic        busy, done, cfg_err, aborted, first_err_valid;
    logic [31:0] err_cnt, first_err_addr;

    mem_scan_ctrl_if #(.WID_MEM(8)) mif ();

    mem_scan_ctrl dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .mode(mode), .seed(seed),
        .start_addr(sa), .end_addr(ea), .abort(abort), .busy(busy), .done(done),
        .cfg_err(cfg_err), .aborted(aborted), .err_cnt(err_cnt),
        .first_err_valid(first_err_valid), .first_err_addr(first_err_addr), .mem(mif)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: registered read, unconditional write, plus bench-side init/corrupt hooks.
    logic [7:0] ram [D];
    logic [7:0] shadow [D];
    logic       init_en = 1'b0, cor_en = 1'b0;
    logic [13:0] cor_addr = '0;
    logic [7:0]  cor_val = '0;

    function automatic logic [7:0] initv(int i);
        return 8'(i * 37 + 11) ^ 8'(i >> 6);
    endfunction

    always @(posedge clk) begin
        if (init_en)
            for (int i = 0; i < D; i++) ram[i] <= initv(i);
        if (cor_en)
            ram[cor_addr] <= cor_val;
        ram[mif.mem_waddr[13:0]] <= mif.mem_din;
        mif.mem_dout <= ram[mif.mem_raddr[13:0]];
    end

    function automatic logic [7:0] pat(logic [1:0] m, logic [7:0] s, int a);
        case (m)
            2'd0:    return s;
            2'd1:    return 8'(a) ^ s;
            default: return ~8'(a) ^ s;
        endcase
    endfunction

    typedef struct {
        int          cyc;
        logic        cfg, abt, fev;
        logic [31:0] err, fea;
    } exp_t;

    exp_t        q[$];
    exp_t        mx;
    int          total = 0, bad = 0;
    logic        m_cfg = 0, m_abt = 0, m_fev = 0;
    logic [31:0] m_err = 0, m_fea = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (!busy || done) begin
                chk("park_waddr", mif.mem_waddr, 32'(PARK));
                chk("park_din", 32'(mif.mem_din), 32'd0);
            end
            if (done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    mx = q.pop_front();
                    chk("done_cycle", 32'(cyc), 32'(mx.cyc));
                    chk("cfg_err", 32'(cfg_err), 32'(mx.cfg));
                    chk("aborted", 32'(aborted), 32'(mx.abt));
                    chk("err_cnt", err_cnt, mx.err);
                    chk("first_err_valid", 32'(first_err_valid), 32'(mx.fev));
                    chk("first_err_addr", first_err_addr, mx.fea);
                end
            end
        end
    end

    task automatic check_reset(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_cfg"}, 32'(cfg_err), 0);
        chk({tag, "_abt"}, 32'(aborted), 0);
        chk({tag, "_err"}, err_cnt, 0);
        chk({tag, "_fev"}, 32'(first_err_valid), 0);
        chk({tag, "_fea"}, first_err_addr, 0);
        chk({tag, "_raddr"}, mif.mem_raddr, 0);
        chk({tag, "_waddr"}, mif.mem_waddr, 32'(PARK));
        chk({tag, "_din"}, 32'(mif.mem_din), 0);
    endtask

    task automatic corrupt(input int a, input logic [7:0] v);
        cor_addr = 14'(a);
        cor_val  = v;
        cor_en   = 1'b1;
        @(negedge clk);
        cor_en    = 1'b0;
        shadow[a] = v;
    endtask

    task automatic mem_check(input string tag);
        int nd = 0, fa = -1;
        for (int i = 0; i < D; i++)
            if (i != PARK && ram[i] !== shadow[i]) begin
                nd++;
                if (fa < 0) fa = i;
            end
        chk({tag, "_ram_diffs"}, 32'(nd), 0);
        if (nd != 0) $display("  first differing address %0d", fa);
    endtask

    task automatic run_op(input logic o, input logic [1:0] m, input logic [7:0] s8,
                          input logic [31:0] s, input logic [31:0] e,
                          input int abort_at, input int rst_at);
        exp_t x;
        int   n = 1, k, lim;
        bit   ok;
        for (int i = 0; i < 20 && busy; i++) @(negedge clk);
        ok = (s <= e) && (e < 32'(D)) && !((s <= 32'(PARK)) && (32'(PARK) <= e)) && (m != 2'd3);
        k  = cyc;
        if (!ok) begin
            m_cfg = 1;
            x.cyc = k + 1;
        end else begin
            n     = int'(e - s) + 1;
            m_cfg = 0; m_abt = 0; m_err = 0; m_fev = 0;
            if (!o) begin
                lim = (abort_at > 0 && abort_at < n) ? abort_at : n;
                for (int i = 0; i < lim; i++) shadow[int'(s) + i] = pat(m, s8, int'(s) + i);
                if (abort_at > 0) begin
                    m_abt = 1;
                    x.cyc = k + abort_at + 1;
                end else begin
                    x.cyc = k + n + 1;
                end
            end else begin
                for (int a = int'(s); a <= int'(e); a++)
                    if (shadow[a] != pat(m, s8, a)) begin
                        m_err++;
                        if (!m_fev) begin
                            m_fev = 1;
                            m_fea = 32'(a);
                        end
                    end
                x.cyc = k + n + 2;
            end
        end
        x.cfg = m_cfg; x.abt = m_abt; x.fev = m_fev; x.err = m_err; x.fea = m_fea;
        if (rst_at == 0) q.push_back(x);
        start = 1'b1; op = o; mode = m; seed = s8; sa = s; ea = e;
        @(negedge clk);
        start = 1'b0;
        if (abort_at > 0) begin
            while (cyc < k + abort_at) @(negedge clk);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
        end
        if (rst_at > 0) begin
            while (cyc < k + rst_at) @(negedge clk);
            reset_n = 1'b0;
            #1;
            check_reset("midrst");
            q.delete();
            m_cfg = 0; m_abt = 0; m_fev = 0; m_err = 0; m_fea = 0;
            @(negedge clk);
            @(negedge clk);
            reset_n = 1'b1;
            return;
        end
        for (int i = 0; i < (ok ? n : 0) + 50 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            chk("done_timeout", 32'(q.size()), 0);
            q.delete();
        end
    endtask

    initial begin
        logic        ro;
        logic [1:0]  rm;
        logic [7:0]  rs;
        logic [31:0] s, e;
        #1 reset_n = 1'b0;
        for (int i = 0; i < D; i++) shadow[i] = initv(i);
        init_en = 1'b1;
        @(negedge clk);
        init_en = 1'b0;
        @(negedge clk);
        check_reset("reset");
        reset_n = 1'b1;
        @(negedge clk);

        run_op(0, 2'd0, 8'hA5, 0, 15, 0, 0);
        run_op(1, 2'd0, 8'hA5, 0, 15, 0, 0);
        mem_check("fill_const");

        run_op(0, 2'd1, 8'h00, 100, 131, 0, 0);
        corrupt(107, 8'hFF);
        corrupt(120, 8'h00);
        run_op(1, 2'd1, 8'h00, 100, 131, 0, 0);

        run_op(0, 2'd0, 8'h5A, 0, 16383, 0, 0);
        run_op(0, 2'd3, 8'h11, 20, 30, 0, 0);
        run_op(1, 2'd0, 8'h11, 10, 5, 0, 0);
        mem_check("rejects");

        run_op(0, 2'd2, 8'h3C, 0, 999, 50, 0);
        mem_check("abort_fill");

        run_op(0, 2'd0, 8'h77, 500, 500, 0, 0);
        run_op(1, 2'd0, 8'h77, 500, 500, 0, 0);
        run_op(1, 2'd1, 8'h77, 500, 500, 0, 0);

        corrupt(33, 8'h99);
        run_op(1, 2'd2, 8'h3C, 0, 255, 0, 80);
        run_op(1, 2'd2, 8'h3C, 0, 255, 0, 0);

        for (int it = 0; it < 30; it++) begin
            ro = 1'($urandom_range(0, 1));
            rm = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            rs = 8'($urandom);
            s  = 32'($urandom_range(0, 16300));
            e  = s + 32'($urandom_range(0, 60));
            if ($urandom_range(0, 7) == 0 && s > 8) e = s - 32'($urandom_range(1, 6));
            if (ro && $urandom_range(0, 1) == 1) run_op(0, rm, rs, s, e, 0, 0);
            if (ro && s <= e && e < 32'(PARK) && $urandom_range(0, 1) == 1)
                corrupt(int'(s) + int'($urandom_range(0, int'(e - s))), 8'($urandom));
            run_op(ro, rm, rs, s, e, 0, 0);
        end

        repeat (10) @(negedge clk);
        mem_check("final");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
